nco_sweep_ctrl: RTL
===================

# nco_sweep_ctrl

Sequences the phase-increment input of the NCO to produce programmable Doppler/frequency sweeps for the spoofer carrier path. It accepts one sweep descriptor through a valid/ready handshake: start increment, signed step, step count and dwell length. It drives the NCO's `phi_inc_i` and `clken`, waits for the NCO pipeline to report valid output, then holds each frequency for an exact number of cycles before stepping. It sits between the control-register/sequencer logic and the NCO instance.

## Interface
Parameters:
- `APR`, 32: phase-increment width; matches the NCO accumulator width.
- `NSTEP_W`, 16: step-count width.
- `DWELL_W`, 24: dwell-counter width.

Ports:
- `clk`  in  1  — single clock for the block.
- `reset_n`  in  1  — reset, synchronous, active-low.
- `cfg_valid`  in  1  — sweep descriptor present.
- `cfg_ready`  out  1  — descriptor accepted when `cfg_valid & cfg_ready`.
- `cfg_start`  in  APR  — first phase increment (unsigned).
- `cfg_step`  in  APR  — per-step increment delta (two's complement).
- `cfg_nsteps`  in  NSTEP_W  — number of steps after the first frequency. 0 means a single dwell.
- `cfg_dwell`  in  DWELL_W  — cycles per frequency. 0 is treated as 1.
- `abort`  in  1  — terminate the sweep.
- `nco_out_valid`  in  1  — `out_valid` from the NCO.
- `phi_inc_o`  out  APR  — to NCO `phi_inc_i`. Registered.
- `nco_clken_o`  out  1  — to NCO `clken`. Registered.
- `busy`  out  1  — sweep in progress.
- `step_idx`  out  NSTEP_W  — index of the current frequency, starting at 0.
- `step_strobe`  out  1  — one-cycle pulse when `phi_inc_o` takes a stepped value.
- `done`  out  1  — one-cycle pulse on normal completion.

## Operation
The block is a state machine with four states: IDLE, PRIME, DWELL and DONE.

- **Reset values:** state=IDLE, `phi_inc_o`=0, `nco_clken_o`=0, `busy`=0, `step_idx`=0, `step_strobe`=0, `done`=0.
- **IDLE:**
  - `cfg_ready` = (state==IDLE) & ~`abort`. It is 0 in every other state.
  - On acceptance, the block latches step, nsteps and dwell (applying `max(dwell,1)`).
  - `phi_inc_o` ← `cfg_start`, `step_idx` ← 0, then the state moves to PRIME.
- **PRIME:** `nco_clken_o`=1, `busy`=1. The block waits for `nco_out_valid`=1. On that sample it loads the dwell counter with dwell−1 and moves to DWELL.
- **DWELL:** `nco_clken_o`=1, `busy`=1. Each cycle the dwell counter decrements. When the counter is 0:
  - If `step_idx` == nsteps, the state moves to DONE.
  - Otherwise:
    - `phi_inc_o` ← `phi_inc_o` + step, modulo 2^APR. Wrap-around is intentional and no saturation is applied.
    - `step_idx` increments.
    - `step_strobe`=1 on the following cycle, coincident with the new `phi_inc_o`.
    - The counter reloads dwell−1.
- **DONE:** held for one cycle with `done`=1, `busy`=0 and `nco_clken_o`=1. The state then moves to IDLE.
- **Leaving to IDLE:** `nco_clken_o` ← 0, which freezes the NCO. `phi_inc_o` holds its last value.
- **Abort:**
  - When asserted in PRIME, DWELL or DONE, the next state is IDLE. `done` is not pulsed, `step_strobe` is suppressed, and `phi_inc_o` holds.
  - Abort has priority over a same-cycle step or completion.
  - Abort in IDLE blocks acceptance for that cycle only.
- **`nco_out_valid` outside PRIME:** ignored, including when it deasserts during DWELL.
- **Reset mid-sweep:** all registers return to their reset values on the next edge, regardless of state.

## Timing
- The descriptor is accepted at edge N. PRIME is active and `phi_inc_o`=start from N+1.
- `nco_out_valid` is sampled high at edge P. DWELL runs from P+1.
- Each frequency, including the first, is visible during exactly `dwell` DWELL cycles.
- A new frequency appears on the cycle immediately after the last dwell cycle of the previous one. There is no gap cycle.
- Total DWELL cycles = (nsteps+1)·dwell. `done` is high exactly one cycle after the final dwell cycle.
- The earliest new acceptance is 2 cycles after the `done` pulse begins: DONE, then IDLE.

## Structure
- Shared package `nco_ctrl_pkg`, containing:
  - the state enum (IDLE/PRIME/DWELL/DONE);
  - the default width constants APR=32, NSTEP_W=16, DWELL_W=24;
  - the `max(dwell,1)` normalisation function.
- One natural sub-module, `nco_dwell_cnt`: a loadable down-counter with `load`, `load_val`, `en` and a `zero` flag.
- The accumulator add and the state machine live in the top level.

## Test plan
- **Basic sweep:**
  - Stimulus: start=0x0100_0000, step=0x0000_1000, nsteps=3, dwell=5, NCO valid 9 cycles after clken.
  - Response: `phi_inc_o` sequence 0x0100_0000, 0x0100_1000, 0x0100_2000, 0x0100_3000, with each value held 5 DWELL cycles. There are 3 `step_strobe` pulses, `done` goes high 20 DWELL cycles after entering DWELL, and clken drops in IDLE.
- **Negative step with wrap:**
  - Stimulus: start=0x0000_0800, step=0xFFFF_F000 (−4096), nsteps=1, dwell=1.
  - Response: second value is 0xFFFF_F800, and each value is held 1 cycle.
- **Degenerate configuration:**
  - Stimulus: nsteps=0, dwell=0.
  - Response: exactly 1 DWELL cycle, no `step_strobe`, and a `done` pulse.
- **Abort mid-DWELL:**
  - Stimulus: abort at step_idx=2.
  - Response: IDLE next cycle, no `done`, `phi_inc_o` holds the step-2 value, and `cfg_ready`=1 the following cycle.
- **Handshake corners:**
  - Stimulus: `cfg_valid` held high while busy, and `cfg_valid`+`abort` together in IDLE.
  - Response: no acceptance until IDLE, and no acceptance during the abort cycle.
- **Reset mid-PRIME:**
  - Stimulus: `reset_n`=0 for 1 cycle during PRIME.
  - Response: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller.
//   sweep_state_t : controller FSM states
//   *_DEF         : default widths (phase increment, step count, dwell counter)
//   dwell_norm()  : maps a dwell of 0 onto 1 so every frequency lasts at least a cycle
package nco_ctrl_pkg;

  localparam int APR_DEF     = 32;
  localparam int NSTEP_W_DEF = 16;
  localparam int DWELL_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_t;

  // Works on a 32-bit container so any dwell width up to 32 can use it.
  function automatic logic [31:0] dwell_norm(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/nco_dwell_cnt.sv
// Loadable down-counter that times how long each frequency is held.
//   clk, reset_n : clock, synchronous active-low reset
//   load         : load load_val (wins over en)
//   load_val     : value loaded on load
//   en           : decrement by one
//   zero         : count is zero
module nco_dwell_cnt #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Drives the NCO phase increment through a programmed frequency sweep.
// A descriptor (start, signed step, step count, dwell) is taken over a
// valid/ready handshake. The NCO is clocked while PRIME waits for its pipeline
// to report valid; DWELL then holds each frequency for exactly `dwell` cycles
// and steps straight into the next one with no gap.
//   clk, reset_n   : clock, synchronous active-low reset
//   cfg_*          : sweep descriptor and handshake
//   abort          : end the sweep immediately (no done pulse)
//   nco_out_valid  : NCO output valid, only looked at in PRIME
//   phi_inc_o      : phase increment to the NCO (registered)
//   nco_clken_o    : NCO clock enable (registered)
//   busy, step_idx : sweep status / current frequency index
//   step_strobe    : pulse in the first cycle of each stepped frequency
//   done           : pulse on normal completion
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int APR     = APR_DEF,
  parameter int NSTEP_W = NSTEP_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [APR-1:0]     cfg_start,
  input  logic [APR-1:0]     cfg_step,
  input  logic [NSTEP_W-1:0] cfg_nsteps,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               abort,
  input  logic               nco_out_valid,
  output logic [APR-1:0]     phi_inc_o,
  output logic               nco_clken_o,
  output logic               busy,
  output logic [NSTEP_W-1:0] step_idx,
  output logic               step_strobe,
  output logic               done
);

  sweep_state_t       state, state_nx;
  logic [APR-1:0]     step;
  logic [NSTEP_W-1:0] nsteps;
  logic [DWELL_W-1:0] dwell;
  logic               accept;
  logic               cnt_load, cnt_en, cnt_zero;
  logic               do_step;

  assign cfg_ready = (state == ST_IDLE) && !abort;
  assign accept    = cfg_valid && cfg_ready;

  nco_dwell_cnt #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (dwell - DWELL_W'(1)),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // Abort is tested first in every active state so it beats a same-cycle
  // step or completion.
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    do_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_PRIME;
      end
      ST_PRIME: begin
        if (abort) state_nx = ST_IDLE;
        else if (nco_out_valid) begin
          cnt_load = 1'b1;
          state_nx = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (abort) state_nx = ST_IDLE;
        else if (cnt_zero) begin
          if (step_idx == nsteps) state_nx = ST_DONE;
          else begin
            do_step  = 1'b1;
            cnt_load = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      phi_inc_o   <= '0;
      nco_clken_o <= 1'b0;
      busy        <= 1'b0;
      step_idx    <= '0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      step        <= '0;
      nsteps      <= '0;
      dwell       <= '0;
    end else begin
      state       <= state_nx;
      nco_clken_o <= (state_nx != ST_IDLE);
      busy        <= (state_nx == ST_PRIME) || (state_nx == ST_DWELL);
      done        <= (state_nx == ST_DONE);
      step_strobe <= do_step;
      if (accept) begin
        phi_inc_o <= cfg_start;
        step_idx  <= '0;
        step      <= cfg_step;
        nsteps    <= cfg_nsteps;
        dwell     <= DWELL_W'(dwell_norm(32'(cfg_dwell)));
      end else if (do_step) begin
        // Modulo-2^APR add; wrap is the intended behaviour for negative steps.
        phi_inc_o <= phi_inc_o + step;
        step_idx  <= step_idx + NSTEP_W'(1);
      end
    end
  end

endmodule
